// File: rtl/sig_dump_pkg.sv
// Shared definitions for the signature dumper.
// Holds the default MMIO base of the halt register, the register slot
// numbers (each register occupies one XLEN/8-byte slot above the base)
// and the dump state enumeration.
package sig_dump_pkg;

  localparam logic [31:0] ADDR_HALT_DEFAULT = 32'h2000_0000;

  // Register slots relative to ADDR_HALT, in units of XLEN/8 bytes.
  localparam int unsigned HALT_SLOT      = 0;
  localparam int unsigned SIG_BEGIN_SLOT = 1;
  localparam int unsigned SIG_END_SLOT   = 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } dump_state_e;

endpackage

// File: rtl/sig_dumper.sv
// Signature dumper: watches CPU stores for three MMIO registers
// (halt, sig_begin, sig_end). On a halt command it stalls the CPU and
// streams the 32-bit words in [sig_begin, sig_end) out of memory over a
// valid/ready port, then reports done until reset.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   store, address,     CPU data store strobe, byte address and data
//   store_data
//   mem_rd_en,          memory read request / aligned byte address;
//   mem_rd_addr,        mem_rd_data is valid one cycle after mem_rd_en
//   mem_rd_data
//   sig_valid,          signature word stream; sig_last flags the
//   sig_ready,          final word
//   sig_data, sig_last
//   cpu_halt            CPU stall request, high in every non-IDLE state
//   done                dump finished, sticky until reset
module sig_dumper
  import sig_dump_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  ADDR_HALT = XLEN'(ADDR_HALT_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_rd_en,
  output logic [XLEN-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic            sig_valid,
  input  logic            sig_ready,
  output logic [31:0]     sig_data,
  output logic            sig_last,
  output logic            cpu_halt,
  output logic            done
);

  localparam logic [XLEN-1:0] HALT_ADDR  = ADDR_HALT + XLEN'(HALT_SLOT * (XLEN / 8));
  localparam logic [XLEN-1:0] BEGIN_ADDR = ADDR_HALT + XLEN'(SIG_BEGIN_SLOT * (XLEN / 8));
  localparam logic [XLEN-1:0] END_ADDR   = ADDR_HALT + XLEN'(SIG_END_SLOT * (XLEN / 8));

  // Mask that clears the byte-within-bus-word bits of a dump address.
  localparam logic [31:0] ALIGN_MASK = ~32'(XLEN / 8 - 1);
  // Mask that selects which 32-bit lane of the bus word holds cur_addr.
  localparam logic [31:0] LANE_MASK  = 32'(XLEN / 32 - 1);

  dump_state_e state, state_next;

  logic [31:0] sig_begin;
  logic [31:0] sig_end;
  logic [31:0] cur_addr;
  logic        halt_hit;
  logic        last_beat;
  logic [31:0] rd_lane;

  // The register file is only writable while IDLE, so everything below
  // is frozen from the halt onward.
  assign halt_hit = (state == IDLE) && store && (address == HALT_ADDR)
                    && (store_data[31:0] == 32'd1);

  // Widened to 33 bits so that the step past 32'hFFFF_FFFC carries out
  // and still compares as the final beat instead of wrapping to zero.
  assign last_beat = ({1'b0, cur_addr} + 33'd4) >= {1'b0, sig_end};

  // Pick the 32-bit lane of the returned bus word that cur_addr points
  // at; for a 32-bit bus the lane index is always zero.
  assign rd_lane = 32'(mem_rd_data >> (32 * ((cur_addr >> 2) & LANE_MASK)));

  assign cpu_halt = (state != IDLE);
  assign done     = (state == DONE);

  // State, register file, dump pointer and output word register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sig_begin <= '0;
      sig_end   <= '0;
      cur_addr  <= '0;
      sig_data  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && store) begin
        if (address == BEGIN_ADDR) sig_begin <= {store_data[31:2], 2'b00};
        if (address == END_ADDR)   sig_end   <= {store_data[31:2], 2'b00};
      end
      if (halt_hit) cur_addr <= sig_begin;
      if (state == WAIT) sig_data <= rd_lane;
      if (state == SEND && sig_ready) cur_addr <= cur_addr + 32'd4;
    end
  end

  // Next-state and per-state outputs. An empty or inverted range goes
  // straight to DONE so no beat is ever produced for it.
  always_comb begin
    state_next  = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    sig_valid   = 1'b0;
    sig_last    = 1'b0;
    case (state)
      IDLE: begin
        if (halt_hit) state_next = (sig_end > sig_begin) ? READ : DONE;
      end
      READ: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = XLEN'(cur_addr & ALIGN_MASK);
        state_next  = WAIT;
      end
      WAIT: begin
        state_next = SEND;
      end
      SEND: begin
        sig_valid = 1'b1;
        sig_last  = last_beat;
        if (sig_ready) state_next = last_beat ? DONE : READ;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
